// File: rtl/program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : program_counter                                              |
// | Description : Program counter with RUN/HALT control and sticky wrap flag.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module program_counter #(
  parameter int                   WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VEC = '0,
  parameter logic [4:0]           CS_FETCH  = 5'b00001,
  parameter logic [4:0]           CS_JMP    = 5'b10000,
  parameter logic [4:0]           CS_JZ     = 5'b10001,
  parameter logic [4:0]           CS_CALL   = 5'b11101,
  parameter logic [4:0]           CS_RET    = 5'b11110,
  parameter logic [4:0]           CS_HALT   = 5'b11111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       cs,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic [WIDTH-1:0] pila,
  input  logic             zero,
  input  logic             run,
  output logic [WIDTH-1:0] pcout,
  output logic             halted,
  output logic             wrapped
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_pc_at_max;
  logic             r_wrapped;
  logic             w_wrapped_nxt;

  assign w_pc_inc    = r_pc + c_one;
  assign w_pc_at_max = &r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_VEC;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_wrapped <= w_wrapped_nxt;
    end
  end

  // Unlisted codes (including the stack-capture state and X) fall to hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_wrapped_nxt = r_wrapped;
    case (r_state)
      ST_RUN: begin
        case (cs)
          CS_FETCH: begin
            w_pc_nxt = w_pc_inc;
            if (w_pc_at_max) w_wrapped_nxt = 1'b1;
          end
          CS_JMP:  w_pc_nxt = jmp_addr;
          CS_JZ: begin
            if (zero) begin
              w_pc_nxt = jmp_addr;
            end else begin
              w_pc_nxt = w_pc_inc;
              if (w_pc_at_max) w_wrapped_nxt = 1'b1;
            end
          end
          CS_CALL: w_pc_nxt    = jmp_addr;
          CS_RET:  w_pc_nxt    = pila;
          CS_HALT: w_state_nxt = ST_HALT;
          default: w_pc_nxt    = r_pc;
        endcase
      end
      ST_HALT: begin
        if (run) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign pcout   = r_pc;
  assign halted  = (r_state == ST_HALT);
  assign wrapped = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_program_counter                                           |
// | Description : Scoreboard-driven self-checking bench for program_counter.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_program_counter;

  localparam logic [4:0] c_fetch = 5'b00001;
  localparam logic [4:0] c_jmp   = 5'b10000;
  localparam logic [4:0] c_jz    = 5'b10001;
  localparam logic [4:0] c_cap   = 5'b11100;
  localparam logic [4:0] c_call  = 5'b11101;
  localparam logic [4:0] c_ret   = 5'b11110;
  localparam logic [4:0] c_halt  = 5'b11111;
  localparam logic [4:0] c_idle  = 5'b00000;

  typedef struct packed {
    logic [7:0] pc;
    logic       halted;
    logic       wrapped;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] cs;
  logic [7:0] jmp_addr;
  logic [7:0] pila;
  logic       zero;
  logic       run;
  logic [7:0] pcout;
  logic       halted;
  logic       wrapped;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  program_counter dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .jmp_addr (jmp_addr),
    .pila     (pila),
    .zero     (zero),
    .run      (run),
    .pcout    (pcout),
    .halted   (halted),
    .wrapped  (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one control word across a rising edge, then sample 1 time unit later.
  task automatic drive(input logic [4:0] c, input logic [7:0] j, input logic [7:0] p,
                       input logic z, input logic r);
    cs = c; jmp_addr = j; pila = p; zero = z; run = r;
    @(posedge clk);
    #1;
    cs = c_idle; run = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(c_jmp, 8'hFF, 8'h00, 1'b0, 1'b0);
    drive(c_fetch, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(c_jmp, 8'h37, 8'h00, 1'b0, 1'b0);
    drive(c_halt, 8'h00, 8'h00, 1'b0, 1'b0);
    sb.push_back('{pc: 8'h37, halted: 1'b1, wrapped: 1'b1});
    e = sb.pop_front();
    n_cmp++;
    if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
      n_err++;
      $display("FAIL reset_pre: got pc=%h h=%b w=%b want pc=%h h=%b w=%b",
               pcout, halted, wrapped, e.pc, e.halted, e.wrapped);
    end
    #2 reset = 1'b0;
    #1;
    sb.push_back('{pc: 8'h00, halted: 1'b0, wrapped: 1'b0});
    e = sb.pop_front();
    n_cmp++;
    if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
      n_err++;
      $display("FAIL reset_async: got pc=%h h=%b w=%b want pc=%h h=%b w=%b",
               pcout, halted, wrapped, e.pc, e.halted, e.wrapped);
    end
    // Inputs held busy while reset is low must have no effect.
    cs = c_fetch; jmp_addr = 8'hAA;
    @(posedge clk); #1;
    sb.push_back('{pc: 8'h00, halted: 1'b0, wrapped: 1'b0});
    e = sb.pop_front();
    n_cmp++;
    if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
      n_err++;
      $display("FAIL reset_dominates: got pc=%h want pc=%h", pcout, e.pc);
    end
    cs = c_idle;
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    exp_t e;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{pc: 8'(i), halted: 1'b0, wrapped: 1'b0});
      drive(c_fetch, 8'h00, 8'h00, 1'b0, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
        n_err++;
        $display("FAIL fetch_%0d: got pc=%h w=%b want pc=%h w=%b", i, pcout, wrapped, e.pc, e.wrapped);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [4:0] cs_l [5] = '{c_jmp, c_fetch, c_jmp, c_fetch, c_ret};
    logic [7:0] ad_l [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    exp_t       ex_l [5];
    ex_l[0] = '{pc: 8'hFF, halted: 1'b0, wrapped: 1'b0};
    ex_l[1] = '{pc: 8'h00, halted: 1'b0, wrapped: 1'b1};
    ex_l[2] = '{pc: 8'hFF, halted: 1'b0, wrapped: 1'b1};
    ex_l[3] = '{pc: 8'h00, halted: 1'b0, wrapped: 1'b1};
    ex_l[4] = '{pc: 8'hFF, halted: 1'b0, wrapped: 1'b1};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(ex_l[i]);
      drive(cs_l[i], ad_l[i], ad_l[i], 1'b0, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
        n_err++;
        $display("FAIL wrap_%0d: got pc=%h w=%b want pc=%h w=%b", i, pcout, wrapped, e.pc, e.wrapped);
      end
    end
    // JZ increment path also wraps; clear the flag first via reset.
    #2 reset = 1'b0; #2 reset = 1'b1;
    drive(c_jmp, 8'hFF, 8'h00, 1'b0, 1'b0);
    sb.push_back('{pc: 8'h00, halted: 1'b0, wrapped: 1'b1});
    drive(c_jz, 8'h55, 8'h00, 1'b0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (pcout !== e.pc || wrapped !== e.wrapped) begin
      n_err++;
      $display("FAIL wrap_jz: got pc=%h w=%b want pc=%h w=%b", pcout, wrapped, e.pc, e.wrapped);
    end
    #2 reset = 1'b0; #2 reset = 1'b1;
  endtask

  task automatic test_jz();
    exp_t e;
    sb.push_back('{pc: 8'h40, halted: 1'b0, wrapped: 1'b0});
    drive(c_jz, 8'h40, 8'h00, 1'b1, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (pcout !== e.pc || wrapped !== e.wrapped) begin
      n_err++;
      $display("FAIL jz_taken: got pc=%h want pc=%h", pcout, e.pc);
    end
    sb.push_back('{pc: 8'h41, halted: 1'b0, wrapped: 1'b0});
    drive(c_jz, 8'h40, 8'h00, 1'b0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (pcout !== e.pc || wrapped !== e.wrapped) begin
      n_err++;
      $display("FAIL jz_not_taken: got pc=%h want pc=%h", pcout, e.pc);
    end
  endtask

  task automatic test_call_ret();
    exp_t e;
    logic [4:0] cs_l [6] = '{c_jmp, c_cap, c_call, c_ret, 5'b01010, 5'b00010};
    logic [7:0] ad_l [6] = '{8'h12, 8'h99, 8'h80, 8'h77, 8'h66, 8'h55};
    logic [7:0] pl_l [6] = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h33, 8'h44};
    logic [7:0] pc_l [6] = '{8'h12, 8'h12, 8'h80, 8'h12, 8'h12, 8'h12};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{pc: pc_l[i], halted: 1'b0, wrapped: 1'b0});
      drive(cs_l[i], ad_l[i], pl_l[i], 1'b1, 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
        n_err++;
        $display("FAIL callret_%0d: got pc=%h h=%b want pc=%h h=%b", i, pcout, halted, e.pc, e.halted);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    logic [4:0] cs_l [10] = '{c_jmp, c_halt, c_fetch, c_fetch, c_fetch, c_fetch, c_jmp, c_fetch, c_fetch, c_fetch};
    logic       rn_l [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] pc_l [10] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h06, 8'h07};
    logic       hl_l [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{pc: pc_l[i], halted: hl_l[i], wrapped: 1'b0});
      drive(cs_l[i], (i == 0) ? 8'h05 : 8'hC0, 8'h00, 1'b0, rn_l[i]);
      e = sb.pop_front();
      n_cmp++;
      if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
        n_err++;
        $display("FAIL halt_%0d: got pc=%h h=%b want pc=%h h=%b", i, pcout, halted, e.pc, e.halted);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] m_pc;
    logic       m_wr;
    logic [4:0] c;
    logic [7:0] j;
    logic [7:0] p;
    logic       z;
    logic [4:0] pool [6] = '{c_fetch, c_jmp, c_jz, c_call, c_ret, c_cap};
    m_pc = pcout;
    m_wr = wrapped;
    for (int i = 0; i < 40; i++) begin
      c = pool[$urandom_range(0, 5)];
      j = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) j = 8'hFF;
      p = 8'($urandom_range(0, 255));
      z = 1'($urandom_range(0, 1));
      if (c == c_fetch || (c == c_jz && !z)) begin
        if (m_pc == 8'hFF) m_wr = 1'b1;
        m_pc = m_pc + 8'h01;
      end else if (c == c_jmp || c == c_jz || c == c_call) begin
        m_pc = j;
      end else if (c == c_ret) begin
        m_pc = p;
      end
      sb.push_back('{pc: m_pc, halted: 1'b0, wrapped: m_wr});
      drive(c, j, p, z, 1'($urandom_range(0, 1)));
      e = sb.pop_front();
      n_cmp++;
      if (pcout !== e.pc || halted !== e.halted || wrapped !== e.wrapped) begin
        n_err++;
        $display("FAIL b2b_%0d cs=%b: got pc=%h h=%b w=%b want pc=%h h=%b w=%b",
                 i, c, pcout, halted, wrapped, e.pc, e.halted, e.wrapped);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cs = c_idle; jmp_addr = '0; pila = '0; zero = 1'b0; run = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    test_fetch();
    test_reset();
    test_fetch();
    test_wrap();
    test_jz();
    test_call_ret();
    #2 reset = 1'b0; #2 reset = 1'b1;
    test_halt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
